rom_bus_arbiter: RTL and testbench
==================================

# rom_bus_arbiter

Two-master, one-slave bus arbiter and sequencer that shares the instruction ROM between the L1 I-cache refill engine (master 0) and the data-side load path (master 1). It serialises single-word read transactions onto the ROM port and masks the ROM's level-style acknowledge so each request yields exactly one ack. It locks grant for bursts, rotates priority fairly and bounds both burst hold time and slave response time. It sits between the cache/LSU bus masters and the ROM slave port.

## Interface
- TIMEOUT, 16: cycles in REQ without s_ack_i before the transfer is aborted with error (≥2).
- MAX_BURST, 8: acks a locked master may receive before yielding to a waiting master (≥1).

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- m0_cyc_i / m1_cyc_i  in  1  master bus-cycle (lock) request.
- m0_stb_i / m1_stb_i  in  1  master transfer strobe.
- m0_we_i / m1_we_i  in  1  write request; ROM is read-only.
- m0_addr_i / m1_addr_i  in  32  byte address.
- m0_ack_o / m1_ack_o  out  1  one-cycle transfer done.
- m0_err_o / m1_err_o  out  1  one-cycle transfer failed (write or timeout).
- m0_data_o / m1_data_o  out  32  read data, valid with ack, else 0.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  constant 0.
- s_sel_o  out  4  constant 4'hF.
- s_addr_o  out  32  registered slave address.
- s_data_o  out  32  constant 0.
- s_ack_i  in  1  slave ack (registered in slave, high 1 cycle after cyc&stb, stays high while strobe held).
- s_data_i  in  32  slave read data.
- gnt_o  out  2  one-hot current owner, 00 when idle.

## Operation
- FSM states: IDLE, REQ, GAP.
- IDLE: requesters are masters with cyc&stb. If none, stay. If one, grant it. If both, grant the one not granted last (last pointer resets to m1, so m0 wins first contention). Granted with we=1 → err pulse next cycle, no slave access, go GAP. Else latch addr into s_addr_o and go REQ.
- REQ: s_cyc_o=1, s_stb_o = ~s_ack_i (combinational mask so slave sees strobe drop in ack cycle). On s_ack_i, forward ack and s_data_i to owner combinationally, increment hold count, then go GAP. Timeout counter increments each REQ cycle; at TIMEOUT-1 without ack → owner err pulse, go GAP.
- Owner drops cyc while in REQ: slave transfer completes but ack/err not forwarded. Go GAP, release lock.
- GAP: s_cyc_o=s_stb_o=0. Owner keeps cyc&stb and (hold<MAX_BURST or other master not requesting) → latch new addr, REQ (same owner). Owner keeps cyc&stb but hold==MAX_BURST and other requesting → switch owner, hold=0, REQ/err path for new owner. Owner cyc low → arbitrate as in IDLE, same cycle.
- Hold count clears on owner change or lock release. Last-pointer updates on every grant.
- Non-owner never sees ack/err. Its data output is 0.

## Timing
- Reset: state IDLE. gnt_o=0, s_cyc_o=s_stb_o=0, s_addr_o=0, all m*_ack_o/err_o=0, m*_data_o=0, hold=0, timeout=0, last=m1. Reset mid-transfer drops strobe next cycle and discards any later slave ack.
- Request sampled in cycle T (IDLE) → s_stb_o high T+1 → s_ack_i and m_ack_o in T+2 → GAP T+3 → next REQ T+4 at earliest.
- First-word latency 2 cycles. Sustained throughput 1 word / 3 cycles.
- Write error: request in T → err in T+1.
- Timeout error: REQ entered T+1 → err in T+TIMEOUT.
- Masters must hold stb/addr until ack/err, then present next address by the following (GAP) cycle.

## Test plan
- Reset then m0 reads 0x0000_0010, slave returns 0x3401_0100 → m0_ack_o and data in T+2; s_stb_o high exactly one cycle; gnt_o=01.
- Both masters request simultaneously from reset → m0 granted first. m0 drops cyc after 1 word → m1 granted from GAP, no idle cycle.
- m0 holds cyc for 12 words with m1 requesting, MAX_BURST=8 → m0 gets 8 acks, m1 gets 1, then m0 resumes. Same test with m1 idle → 12 consecutive m0 acks.
- m1 write (we=1) → m1_err_o one cycle at T+1, s_cyc_o never asserted.
- Slave ack held low → err at REQ+TIMEOUT (cycle T+16 for TIMEOUT=16), FSM returns to GAP/IDLE; a late ack is not forwarded.
- rst asserted in REQ cycle → next cycle all outputs at reset values; subsequent m0 read completes normally.

Source files
------------

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter
//
// Purpose:
//   Shares the instruction ROM between two bus masters. Master 0 is the L1
//   I-cache refill engine and master 1 is the data-side load path. The block
//   runs one single-word read at a time on the ROM port. The ROM acknowledge
//   is level style, so the arbiter masks it and each request gets exactly
//   one ack. A master that holds cyc keeps the grant for a burst. The grant
//   is handed to a waiting master after MAX_BURST acks. A transfer that gets
//   no ack within TIMEOUT cycles ends with an error.
//
// Handshake:
//   A master asserts cyc&stb with a stable address (and we). It keeps them
//   until it sees a one-cycle ack (with data) or a one-cycle err. It may show
//   its next address in the cycle after that. cyc low means the master gives
//   up its lock. The slave asserts ack one cycle after cyc&stb and holds it
//   while stb stays high. stb is dropped combinationally in the ack cycle.
//
// Parameters:
//   TIMEOUT    cycles in REQ without an ack before the error abort (>= 2)
//   MAX_BURST  acks a locked master gets before a waiting master wins (>= 1)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   m{0,1}_cyc_i/_stb_i/_we_i   master cycle (lock), strobe, write request
//   m{0,1}_addr_i               master byte address
//   m{0,1}_ack_o/_err_o         one-cycle transfer done / failed
//   m{0,1}_data_o               read data while ack is high, otherwise 0
//   s_cyc_o/_stb_o/_we_o/_sel_o slave control (we tied 0, sel tied F)
//   s_addr_o/_data_o            registered slave address, write data (0)
//   s_ack_i/_data_i             slave acknowledge and read data
//   gnt_o                       one-hot current owner, 00 when idle
//   dbg_state_o                 FSM state (0 IDLE, 1 REQ, 2 GAP)

module rom_bus_arbiter #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_data_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_data_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_data_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  dbg_state_o
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int HW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q;
    logic          owner_q;   // 0 = m0, 1 = m1; only meaningful while gnt_q != 0
    logic          last_q;    // master granted most recently
    logic [1:0]    gnt_q;
    logic [HW-1:0] hold_q;    // acks delivered to the owner in this lock
    logic [TW-1:0] tmo_q;
    logic [31:0]   s_addr_q;
    logic [1:0]    err_q;     // write-reject error pulse, one bit per master

    logic          req0, req1;
    logic          own_cyc, own_req, oth_req;
    logic          arb_any, arb_who;
    logic          grant_en, grant_who, grant_we, keep_lock;
    logic [31:0]   grant_addr;
    logic [HW-1:0] hold_d;
    logic          req_ack, req_err;
    logic          tmo_last, burst_full;

    assign tmo_last   = (tmo_q == TW'(TIMEOUT - 1));
    assign burst_full = (hold_q == HW'(MAX_BURST));

    // Grant decision for IDLE and GAP. The GAP cycle that carries a
    // write-reject error makes no decision, because the master is still
    // holding the rejected request during that cycle.
    always_comb begin
        req0      = m0_cyc_i & m0_stb_i;
        req1      = m1_cyc_i & m1_stb_i;
        own_cyc   = owner_q ? m1_cyc_i : m0_cyc_i;
        own_req   = owner_q ? req1 : req0;
        oth_req   = owner_q ? req0 : req1;
        arb_any   = req0 | req1;
        // On contention the master that was not granted last wins.
        arb_who   = (req0 & req1) ? ~last_q : req1;
        grant_en  = 1'b0;
        grant_who = arb_who;
        keep_lock = 1'b0;
        case (state_q)
            IDLE: grant_en = arb_any;
            GAP: begin
                if (err_q == 2'b00) begin
                    if (own_cyc) begin
                        keep_lock = 1'b1;
                        grant_en  = own_req;
                        grant_who = (burst_full && oth_req) ? ~owner_q : owner_q;
                    end else begin
                        grant_en = arb_any;
                    end
                end
            end
            default: ;
        endcase
        grant_we   = grant_who ? m1_we_i : m0_we_i;
        grant_addr = grant_who ? m1_addr_i : m0_addr_i;
        // The hold count carries over only when the same owner keeps its lock.
        hold_d     = (keep_lock && (grant_who == owner_q)) ? hold_q : '0;
    end

    // Ack and error go out only while the owner still holds its cycle.
    assign req_ack = (state_q == REQ) & s_ack_i & own_cyc;
    assign req_err = (state_q == REQ) & ~s_ack_i & own_cyc & tmo_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            gnt_q    <= 2'b00;
            hold_q   <= '0;
            tmo_q    <= '0;
            s_addr_q <= '0;
            err_q    <= 2'b00;
        end else begin
            err_q <= 2'b00;
            case (state_q)
                IDLE, GAP: begin
                    if (grant_en) begin
                        owner_q <= grant_who;
                        last_q  <= grant_who;
                        gnt_q   <= grant_who ? 2'b10 : 2'b01;
                        hold_q  <= hold_d;
                        tmo_q   <= '0;
                        if (grant_we) begin
                            // ROM is read-only: reject without touching the slave.
                            err_q   <= grant_who ? 2'b10 : 2'b01;
                            state_q <= GAP;
                        end else begin
                            s_addr_q <= grant_addr;
                            state_q  <= REQ;
                        end
                    end else if (state_q == GAP && !own_cyc && err_q == 2'b00) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        hold_q  <= '0;
                    end
                end
                REQ: begin
                    if (!own_cyc) begin
                        // Owner gave up its lock. GAP will arbitrate again.
                        state_q <= GAP;
                        tmo_q   <= '0;
                        hold_q  <= '0;
                    end else if (s_ack_i) begin
                        state_q <= GAP;
                        tmo_q   <= '0;
                        if (!burst_full) begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end else if (tmo_last) begin
                        state_q <= GAP;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_ack_o  = req_ack & ~owner_q;
    assign m1_ack_o  = req_ack & owner_q;
    assign m0_err_o  = err_q[0] | (req_err & ~owner_q);
    assign m1_err_o  = err_q[1] | (req_err & owner_q);
    assign m0_data_o = m0_ack_o ? s_data_i : 32'h0;
    assign m1_data_o = m1_ack_o ? s_data_i : 32'h0;

    // The strobe drops in the ack cycle, so the level-style ack ends after one cycle.
    assign s_cyc_o     = (state_q == REQ);
    assign s_stb_o     = (state_q == REQ) & ~s_ack_i;
    assign s_we_o      = 1'b0;
    assign s_sel_o     = 4'hF;
    assign s_addr_o    = s_addr_q;
    assign s_data_o    = 32'h0;
    assign gnt_o       = gnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rom_bus_arbiter.sv
module tb_rom_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_data, m1_data;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  gnt, dbg_state;

  rom_bus_arbiter #(.TIMEOUT(16), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_data_o(m0_data),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_data_o(m1_data),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_addr_o(s_addr), .s_data_o(s_wdata), .s_ack_i(s_ack), .s_data_i(s_rdata),
    .gnt_o(gnt), .dbg_state_o(dbg_state)
  );

  // ---------------- ROM slave model ----------------
  logic        slave_en  = 1'b1;
  logic        force_ack = 1'b0;
  logic        ack_q     = 1'b0;
  logic [31:0] rd_q      = 32'h0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h3401_0000 | (a << 4);
  endfunction

  always @(posedge clk) begin
    ack_q <= slave_en & s_cyc & s_stb;
    rd_q  <= rom_word(s_addr);
  end
  assign s_ack   = ack_q | force_ack;
  assign s_rdata = rd_q;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_m0(input logic c, input logic s, input logic w, input logic [31:0] a);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_addr = a;
  endtask

  task automatic drive_m1(input logic c, input logic s, input logic w, input logic [31:0] a);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_addr = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_m0(0, 0, 0, 32'h0);
    drive_m1(0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // m0 issues 12 reads at 0x100 + 4*i. m1 optionally issues one read at 0x200
  // and drops cyc in the GAP cycle after its ack.
  task automatic run_burst(input bit with_m1, input string name);
    int k0, k1, idx, errs;
    logic [32:0] e;
    k0 = 0; k1 = 0; idx = 0; errs = 0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (with_m1 && i == 8) exp_q.push_back({1'b1, rom_word(32'h200)});
      exp_q.push_back({1'b0, rom_word(32'h100 + 32'(4 * i))});
    end
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      drive_m0(k0 < 12, k0 < 12, 1'b0, 32'h100 + 32'(4 * k0));
      drive_m1(with_m1 && k1 < 1, with_m1 && k1 < 1, 1'b0, 32'h200);
      #1;
      if (m0_ack || m1_ack) begin
        check({name, "_ack_onehot"}, {32'h0, m0_ack & m1_ack}, 33'h0);
        check({name, "_q_nonempty"}, {32'h0, exp_q.size() != 0}, 33'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({name, "_word"}, {m1_ack, m1_ack ? m1_data : m0_data}, e);
          check({name, "_cycle"}, 33'(cyc), 33'(2 + 3 * idx));
        end
        idx++;
        if (m0_ack) k0++;
        if (m1_ack) k1++;
      end
      errs += int'(m0_err) + int'(m1_err);
    end
    check({name, "_m0_acks"}, 33'(k0), 33'd12);
    check({name, "_m1_acks"}, 33'(k1), with_m1 ? 33'd1 : 33'd0);
    check({name, "_left"}, 33'(exp_q.size()), 33'd0);
    check({name, "_errs"}, 33'(errs), 33'd0);
    check({name, "_end_gnt"}, {31'h0, gnt}, 33'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_m0(0, 0, 0, 32'h0);
    drive_m1(0, 0, 0, 32'h0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_gnt",   {31'h0, gnt}, 33'h0);
    check("rst_cyc",   {32'h0, s_cyc}, 33'h0);
    check("rst_stb",   {32'h0, s_stb}, 33'h0);
    check("rst_addr",  {1'b0, s_addr}, 33'h0);
    check("rst_acks",  {29'h0, m0_ack, m0_err, m1_ack, m1_err}, 33'h0);
    check("rst_state", {31'h0, dbg_state}, 33'd0);
    check("rst_const", {1'b0, s_we, s_sel, s_wdata[27:0]}, {1'b0, 1'b0, 4'hF, 28'h0});
    rst = 1'b0;

    // Single m0 read
    @(negedge clk);
    drive_m0(1, 1, 0, 32'h0000_0010);
    #1;
    check("t1_T_gnt", {31'h0, gnt}, 33'h0);
    check("t1_T_stb", {32'h0, s_stb}, 33'h0);
    @(negedge clk); #1;
    check("t1_T1_stb",  {32'h0, s_stb}, 33'h1);
    check("t1_T1_cyc",  {32'h0, s_cyc}, 33'h1);
    check("t1_T1_addr", {1'b0, s_addr}, {1'b0, 32'h0000_0010});
    check("t1_T1_gnt",  {31'h0, gnt}, 33'h1);
    check("t1_T1_ack",  {32'h0, m0_ack}, 33'h0);
    @(negedge clk); #1;
    check("t1_T2_ack",   {32'h0, m0_ack}, 33'h1);
    check("t1_T2_data",  {1'b0, m0_data}, {1'b0, 32'h3401_0100});
    check("t1_T2_stb",   {32'h0, s_stb}, 33'h0);
    check("t1_T2_m1",    {m1_ack, m1_data}, 33'h0);
    @(negedge clk);
    drive_m0(0, 0, 0, 32'h0);
    #1;
    check("t1_T3_state", {31'h0, dbg_state}, 33'd2);
    check("t1_T3_stb",   {32'h0, s_stb}, 33'h0);
    check("t1_T3_ack",   {32'h0, m0_ack}, 33'h0);
    @(negedge clk); #1;
    check("t1_T4_state", {31'h0, dbg_state}, 33'd0);
    check("t1_T4_gnt",   {31'h0, gnt}, 33'h0);

    // Contention from reset: m0 first, then m1 straight from GAP
    do_reset();
    @(negedge clk);
    drive_m0(1, 1, 0, 32'h20);
    drive_m1(1, 1, 0, 32'h40);
    @(negedge clk); #1;
    check("t2_T1_gnt",  {31'h0, gnt}, 33'h1);
    check("t2_T1_addr", {1'b0, s_addr}, {1'b0, 32'h20});
    @(negedge clk); #1;
    check("t2_T2_m0",   {m0_ack, m0_data}, {1'b1, rom_word(32'h20)});
    check("t2_T2_m1",   {m1_ack, m1_data}, 33'h0);
    @(negedge clk);
    drive_m0(0, 0, 0, 32'h0);
    #1;
    check("t2_T3_state", {31'h0, dbg_state}, 33'd2);
    @(negedge clk); #1;
    check("t2_T4_gnt",  {31'h0, gnt}, 33'h2);
    check("t2_T4_stb",  {32'h0, s_stb}, 33'h1);
    check("t2_T4_addr", {1'b0, s_addr}, {1'b0, 32'h40});
    @(negedge clk); #1;
    check("t2_T5_m1",   {m1_ack, m1_data}, {1'b1, rom_word(32'h40)});
    check("t2_T5_m0",   {m0_ack, m0_data}, 33'h0);
    @(negedge clk);
    drive_m1(0, 0, 0, 32'h0);
    @(negedge clk); #1;
    check("t2_idle_gnt", {31'h0, gnt}, 33'h0);

    // Burst fairness with m1 waiting, then an uncontended burst
    do_reset();
    run_burst(1'b1, "burst_fair");
    run_burst(1'b0, "burst_solo");

    // m1 write is rejected without a slave access
    @(negedge clk);
    drive_m1(1, 1, 1, 32'h80);
    #1;
    check("t4_T_err",  {32'h0, m1_err}, 33'h0);
    check("t4_T_cyc",  {32'h0, s_cyc}, 33'h0);
    @(negedge clk); #1;
    check("t4_T1_err", {m1_err, m0_err, m1_ack, 30'h0}, {1'b1, 1'b0, 1'b0, 30'h0});
    check("t4_T1_cyc", {32'h0, s_cyc}, 33'h0);
    check("t4_T1_gnt", {31'h0, gnt}, 33'h2);
    @(negedge clk);
    drive_m1(0, 0, 0, 32'h0);
    #1;
    check("t4_T2_err", {32'h0, m1_err}, 33'h0);
    check("t4_T2_cyc", {32'h0, s_cyc}, 33'h0);
    @(negedge clk); #1;
    check("t4_T3_gnt", {31'h0, gnt}, 33'h0);
    check("t4_T3_cyc", {32'h0, s_cyc}, 33'h0);

    // Timeout with a silent slave, then a late ack that must be ignored
    slave_en = 1'b0;
    @(negedge clk);
    drive_m0(1, 1, 0, 32'h300);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      check("t5_wait_err", {31'h0, m0_err, s_stb}, 33'h1);
    end
    @(negedge clk); #1;
    check("t5_err",     {m0_err, m0_ack, m1_err, 30'h0}, {1'b1, 1'b0, 1'b0, 30'h0});
    @(negedge clk);
    drive_m0(0, 0, 0, 32'h0);
    force_ack = 1'b1;
    #1;
    check("t5_state",   {31'h0, dbg_state}, 33'd2);
    check("t5_late",    {m0_ack, m0_err, 31'h0}, 33'h0);
    check("t5_late_d",  {1'b0, m0_data}, 33'h0);
    @(negedge clk);
    force_ack = 1'b0;
    slave_en  = 1'b1;
    #1;
    check("t5_idle", {31'h0, dbg_state}, 33'd0);

    // Reset while a read is in REQ, then the held request completes
    @(negedge clk);
    drive_m0(1, 1, 0, 32'h44);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_req_stb", {32'h0, s_stb}, 33'h1);
    @(negedge clk); #1;
    check("t6_rst_ctl",   {31'h0, s_cyc, s_stb}, 33'h0);
    check("t6_rst_gnt",   {31'h0, gnt}, 33'h0);
    check("t6_rst_addr",  {1'b0, s_addr}, 33'h0);
    check("t6_rst_ack",   {m0_ack, m0_data}, 33'h0);
    check("t6_rst_state", {31'h0, dbg_state}, 33'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("t6_re_stb",  {32'h0, s_stb}, 33'h1);
    check("t6_re_addr", {1'b0, s_addr}, {1'b0, 32'h44});
    check("t6_re_gnt",  {31'h0, gnt}, 33'h1);
    @(negedge clk); #1;
    check("t6_re_ack",  {m0_ack, m0_data}, {1'b1, rom_word(32'h44)});
    @(negedge clk);
    drive_m0(0, 0, 0, 32'h0);
    @(negedge clk); #1;
    check("t6_end_gnt", {31'h0, gnt}, 33'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
